// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage memory access block.
package mem_stage_pkg;

    localparam int unsigned XLEN_DEF   = 64;
    localparam int unsigned ALIGN_BITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_timer.sv
// Counts BUSY cycles of an outstanding data-memory access and flags the abort cycle.
module mem_access_timer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Last BUSY cycle allowed: the access is aborted on this edge.
    assign expired_c = en && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: runs EX/MEM loads/stores on a req/ack data memory, stalls the pipe
// while outstanding and drives the MEM/WB register.
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic            mem_to_reg,
    input  logic [4:0]      addr_wr_reg,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] data_write_mem,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            stall,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic [4:0]      wb_addr_wr_reg,
    output logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] wb_read_data,
    output logic            err_misaligned,
    output logic            err_timeout
);

    mem_state_t state, state_next;

    logic            access_c;
    logic            aligned_c;
    logic            start_c;
    logic            misalign_c;
    logic            timer_en_c;
    logic            expired_c;
    logic            ack_take_c;
    logic            abort_c;

    logic            lat_load;
    logic            lat_reg_write;
    logic            lat_mem_to_reg;
    logic [4:0]      lat_rd;
    logic [XLEN-1:0] lat_rdata;

    assign access_c  = mem_read | mem_write;
    assign aligned_c = (alu_result[ALIGN_BITS-1:0] == '0);

    mem_access_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_c),
        .en        (timer_en_c),
        .expired_c (expired_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control; abort wins over an ack in the same cycle.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        start_c    = 1'b0;
        misalign_c = 1'b0;
        timer_en_c = 1'b0;
        ack_take_c = 1'b0;
        abort_c    = 1'b0;
        case (state)
            IDLE: begin
                if (access_c) begin
                    if (aligned_c) begin
                        start_c    = 1'b1;
                        stall      = 1'b1;
                        state_next = BUSY;
                    end else begin
                        misalign_c = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall      = 1'b1;
                timer_en_c = 1'b1;
                if (expired_c) begin
                    abort_c    = 1'b1;
                    state_next = DONE;
                end else if (dmem_ack) begin
                    ack_take_c = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory request and access latches; both-set access is treated as a store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            lat_load       <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            lat_rd         <= '0;
            lat_rdata      <= '0;
            err_timeout    <= 1'b0;
            err_misaligned <= 1'b0;
        end else begin
            err_timeout    <= abort_c;
            err_misaligned <= misalign_c;
            if (start_c) begin
                dmem_req       <= 1'b1;
                dmem_we        <= mem_write;
                dmem_addr      <= alu_result;
                dmem_wdata     <= data_write_mem;
                lat_load       <= mem_read & ~mem_write;
                lat_reg_write  <= reg_write;
                lat_mem_to_reg <= mem_to_reg;
                lat_rd         <= addr_wr_reg;
                lat_rdata      <= '0;
            end
            if (ack_take_c || abort_c) begin
                dmem_req <= 1'b0;
            end
            if (ack_take_c && lat_load) begin
                lat_rdata <= dmem_rdata;
            end
            if (abort_c) begin
                lat_reg_write <= 1'b0;
            end
        end
    end

    // MEM/WB register: bubble while stalled, latched result on DONE, pass-through otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_addr_wr_reg <= '0;
            wb_result      <= '0;
            wb_read_data   <= '0;
        end else if (stall) begin
            wb_reg_write <= 1'b0;
        end else if (state == DONE) begin
            wb_reg_write   <= lat_reg_write;
            wb_mem_to_reg  <= lat_mem_to_reg;
            wb_addr_wr_reg <= lat_rd;
            wb_result      <= dmem_addr;
            wb_read_data   <= lat_rdata;
        end else begin
            wb_reg_write   <= reg_write & ~misalign_c;
            wb_mem_to_reg  <= mem_to_reg;
            wb_addr_wr_reg <= addr_wr_reg;
            wb_result      <= alu_result;
            wb_read_data   <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: vector table with a scoreboard queue
// plus hand sequences for spurious ack and mid-access reset.
module tb_mem_stage_access;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic [4:0]      addr_wr_reg;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] data_write_mem;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;
    logic            stall;
    logic            wb_reg_write;
    logic            wb_mem_to_reg;
    logic [4:0]      wb_addr_wr_reg;
    logic [XLEN-1:0] wb_result;
    logic [XLEN-1:0] wb_read_data;
    logic            err_misaligned;
    logic            err_timeout;

    mem_stage_access #(
        .XLEN        (XLEN),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .addr_wr_reg    (addr_wr_reg),
        .alu_result     (alu_result),
        .data_write_mem (data_write_mem),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .stall          (stall),
        .wb_reg_write   (wb_reg_write),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_addr_wr_reg (wb_addr_wr_reg),
        .wb_result      (wb_result),
        .wb_read_data   (wb_read_data),
        .err_misaligned (err_misaligned),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ack_dly: BUSY cycle (1-based) in which ack is given, 0 = never.
    typedef struct {
        logic            rd_en;
        logic            wr_en;
        logic            rw;
        logic            m2r;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] wdata;
        int              ack_dly;
        logic [XLEN-1:0] rdata;
        logic            e_rw;
        logic [XLEN-1:0] e_rdata;
        int              e_busy;
        logic            e_mis;
        logic            e_to;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];
    int   errors;
    int   checks;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        reg_write      = 1'b0;
        mem_to_reg     = 1'b0;
        addr_wr_reg    = '0;
        alu_result     = '0;
        data_write_mem = '0;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   busy;
        int   stl;
        int   bub_bad;
        int   req_bad;
        logic to_seen;
        busy    = 0;
        stl     = 0;
        bub_bad = 0;
        req_bad = 0;
        @(negedge clk);
        mem_read       = v.rd_en;
        mem_write      = v.wr_en;
        reg_write      = v.rw;
        mem_to_reg     = v.m2r;
        addr_wr_reg    = v.rd;
        alu_result     = v.alu;
        data_write_mem = v.wdata;
        sb.push_back(v);
        forever begin
            #1;
            if (dmem_req) begin
                busy++;
                if (dmem_we !== v.wr_en || dmem_addr !== v.alu || (v.wr_en && dmem_wdata !== v.wdata))
                    req_bad++;
                dmem_ack   = (busy == v.ack_dly);
                dmem_rdata = v.rdata;
            end
            if (!stall) break;
            stl++;
            if (stl > 200) begin
                chk("stall_bound", 64'(stl), 64'd0);
                break;
            end
            @(posedge clk);
            #1;
            if (wb_reg_write !== 1'b0) bub_bad++;
            dmem_ack = 1'b0;
            @(negedge clk);
        end
        to_seen = err_timeout;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wb_reg_write", 64'(wb_reg_write), 64'(e.e_rw));
        chk("wb_mem_to_reg", 64'(wb_mem_to_reg), 64'(e.m2r));
        chk("wb_addr_wr_reg", 64'(wb_addr_wr_reg), 64'(e.rd));
        chk("wb_result", wb_result, e.alu);
        chk("wb_read_data", wb_read_data, e.e_rdata);
        chk("err_misaligned", 64'(err_misaligned), 64'(e.e_mis));
        chk("err_timeout_pulse", 64'(to_seen), 64'(e.e_to));
        chk("err_timeout_width", 64'(err_timeout), 64'd0);
        chk("busy_cycles", 64'(busy), 64'(e.e_busy));
        chk("stall_cycles", 64'(stl), (e.e_busy > 0) ? 64'(e.e_busy + 1) : 64'd0);
        chk("bubble_bad_cycles", 64'(bub_bad), 64'd0);
        chk("req_unstable_cycles", 64'(req_bad), 64'd0);
        idle_inputs();
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        idle_inputs();

        //        rd   wr   rw   m2r  rd     alu        wdata    ack rdata     e_rw e_rdata   busy mis  to
        vecs[0] = '{1'b0,1'b0,1'b1,1'b0,5'd5, 64'h2A,   64'h0,   0, 64'h0,    1'b1,64'h0,    0,  1'b0,1'b0};
        vecs[1] = '{1'b1,1'b0,1'b1,1'b1,5'd7, 64'h100,  64'h0,   2, 64'hDEAD, 1'b1,64'hDEAD, 2,  1'b0,1'b0};
        vecs[2] = '{1'b0,1'b1,1'b0,1'b0,5'd0, 64'h108,  64'h55,  3, 64'hF0,   1'b0,64'h0,    3,  1'b0,1'b0};
        vecs[3] = '{1'b1,1'b0,1'b1,1'b1,5'd4, 64'h103,  64'h0,   1, 64'h11,   1'b0,64'h0,    0,  1'b1,1'b0};
        vecs[4] = '{1'b1,1'b0,1'b1,1'b1,5'd8, 64'h200,  64'h0,   0, 64'h77,   1'b0,64'h0,    16, 1'b0,1'b1};
        vecs[5] = '{1'b1,1'b1,1'b0,1'b0,5'd0, 64'h110,  64'h99,  1, 64'h1234, 1'b0,64'h0,    1,  1'b0,1'b0};
        vecs[6] = '{1'b1,1'b0,1'b1,1'b1,5'd9, 64'h118,  64'h0,   1, 64'hCAFE, 1'b1,64'hCAFE, 1,  1'b0,1'b0};
        vecs[7] = '{1'b1,1'b0,1'b1,1'b1,5'd10,64'h120,  64'h0,   16,64'hBEEF, 1'b0,64'h0,    16, 1'b0,1'b1};
        vecs[8] = '{1'b1,1'b0,1'b1,1'b1,5'd11,64'h128,  64'h0,   15,64'h4242, 1'b1,64'h4242, 15, 1'b0,1'b0};
        vecs[9] = '{1'b0,1'b1,1'b0,1'b0,5'd0, 64'h12C,  64'h66,  1, 64'h0,    1'b0,64'h0,    0,  1'b1,1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_wb_result", wb_result, 64'd0);
        chk("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Ack while idle must not leak into the MEM/WB read data.
        @(negedge clk);
        reg_write   = 1'b1;
        addr_wr_reg = 5'd3;
        alu_result  = 64'h5;
        dmem_ack    = 1'b1;
        dmem_rdata  = 64'hBAD;
        #1;
        chk("spur_ack_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        chk("spur_ack_read_data", wb_read_data, 64'd0);
        chk("spur_ack_result", wb_result, 64'h5);
        chk("spur_ack_req", 64'(dmem_req), 64'd0);
        dmem_ack = 1'b0;
        idle_inputs();

        // Reset asserted in the middle of a BUSY access.
        @(negedge clk);
        mem_read    = 1'b1;
        reg_write   = 1'b1;
        addr_wr_reg = 5'd12;
        alu_result  = 64'h300;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_req", 64'(dmem_req), 64'd1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 64'(dmem_req), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_addr", dmem_addr, 64'd0);
        chk("midrst_wb_rd", 64'(wb_addr_wr_reg), 64'd0);
        chk("midrst_wb_result", wb_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(vecs[1]);
        run_vec(vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
